// File: rtl/lcd_bus_arbiter.sv
// rtl/lcd_bus_arbiter.sv - round-robin arbiter and write-timing generator for an HD44780-style LCD bus
module lcd_bus_arbiter #(
    parameter int E_HIGH_CYC    = 1000,
    parameter int E_LOW_CYC     = 1000,
    parameter int CMD_WAIT_CYC  = 5000,
    parameter int LONG_WAIT_CYC = 200000
) (
    input  logic       clk,
    input  logic       reset_btn,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       last_grant
);

    // Counter must cover the longest phase and never be narrower than 18 bits.
    localparam int MAX_AB  = (E_HIGH_CYC > E_LOW_CYC) ? E_HIGH_CYC : E_LOW_CYC;
    localparam int MAX_CD  = (CMD_WAIT_CYC > LONG_WAIT_CYC) ? CMD_WAIT_CYC : LONG_WAIT_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 18) ? $clog2(MAX_CYC + 1) : 18;

    // Each phase ends when the counter reaches its cycle count minus one.
    localparam logic [CNT_W-1:0] E_HIGH_LAST = CNT_W'(E_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] E_LOW_LAST  = CNT_W'(E_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST    = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_E_HIGH,
        S_E_LOW,
        S_WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             can_accept;
    logic             sel1;
    logic             xfer;
    logic             long_cmd;
    logic [CNT_W-1:0] wait_last;

    // The bus is write-only.
    assign lcd_rw = 1'b0;

    // Requester 1 wins when it is alone, or when both ask and requester 0 went last.
    assign sel1       = req1_valid && (!req0_valid || !last_grant);
    assign can_accept = reset_btn && (state == S_IDLE);
    assign req0_ready = can_accept && req0_valid && !sel1;
    assign req1_ready = can_accept && sel1;
    assign xfer       = req0_ready || req1_ready;

    // Clear Display and Return Home (0x01..0x03 as commands) need the long settle time.
    assign long_cmd  = !lcd_rs && ((lcd_data == 8'h01) || (lcd_data == 8'h02) || (lcd_data == 8'h03));
    assign wait_last = long_cmd ? LONG_LAST : CMD_LAST;

    // Write sequencer: latch the granted byte, then setup, E pulse, E low and settle.
    always_ff @(posedge clk or negedge reset_btn) begin
        if (!reset_btn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            lcd_rs     <= 1'b0;
            lcd_e      <= 1'b0;
            lcd_data   <= 8'h00;
            busy       <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        state      <= S_SETUP;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        lcd_rs     <= sel1 ? req1_rs : req0_rs;
                        lcd_data   <= sel1 ? req1_data : req0_data;
                        last_grant <= sel1;
                    end
                end
                S_SETUP: begin
                    state <= S_E_HIGH;
                    cnt   <= '0;
                    lcd_e <= 1'b1;
                end
                S_E_HIGH: begin
                    if (cnt == E_HIGH_LAST) begin
                        state <= S_E_LOW;
                        cnt   <= '0;
                        lcd_e <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_E_LOW: begin
                    if (cnt == E_LOW_LAST) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_WAIT: begin
                    if (cnt == wait_last) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    lcd_e <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Shares one HD44780-style 8-bit character-LCD bus between two requesters, e.g. req0 = init/config sequencer and req1 = text/debug writer.
- Each requester hands over one command or data byte through a valid/ready handshake.
- The block round-robin arbitrates between requesters, then generates the setup, E-pulse and post-write settle timing.
- Sits between the requesters and the LCD pins. It is the only driver of lcd_rs/lcd_rw/lcd_e/lcd_data.

Parameters:
- E_HIGH_CYC, 1000, clock cycles lcd_e held high per write (10 us at 100 MHz).
- E_LOW_CYC, 1000, cycles lcd_e held low after the pulse, before the settle wait.
- CMD_WAIT_CYC, 5000, settle cycles after a normal command or data write (50 us).
- LONG_WAIT_CYC, 200000, settle cycles after Clear Display or Return Home (2 ms).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset_btn  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a byte pending.
- req0_rs  in  1  requester 0 register select: 0 = command, 1 = data.
- req0_data  in  8  requester 0 byte.
- req0_ready  out  1  requester 0 byte accepted this cycle (combinational).
- req1_valid  in  1  requester 1 has a byte pending.
- req1_rs  in  1  requester 1 register select.
- req1_data  in  8  requester 1 byte.
- req1_ready  out  1  requester 1 byte accepted this cycle (combinational).
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  LCD read/write; tied 0 (write only).
- lcd_e  out  1  LCD enable strobe.
- lcd_data  out  8  LCD data bus.
- busy  out  1  a transaction is in progress (state != IDLE).
- last_grant  out  1  index of the most recently accepted requester.

Behaviour:
- Reset (reset_btn = 0, asynchronous, overrides everything, including mid-transaction):
  - state = IDLE, counter = 0.
  - lcd_rs = 0, lcd_e = 0, lcd_data = 8'h00, busy = 0.
  - last_grant = 1, so req0 wins the first contention.
  - Both ready outputs are 0 while reset is asserted.
  - No partial E pulse survives reset: lcd_e drops in the same instant.
- Arbitration:
  - Evaluated only in IDLE.
  - Only one valid: that requester is selected.
  - Both valid: select the requester != last_grant (round-robin).
  - reqN_ready = (state == IDLE) && selected == N. At most one ready is high in any cycle.
  - Transfer occurs when valid && ready. On transfer, rs/data are latched and last_grant updates at the next edge.
- Handshake:
  - ready is never high outside IDLE.
  - A requester must hold valid, rs and data until its ready is seen.
  - Dropping valid before acceptance is legal; the request is simply lost.
- FSM, with a counter of at least 18 bits, reset to 0 on every state change:
  - IDLE: on transfer go to SETUP; otherwise stay. lcd_e = 0.
  - SETUP: 1 cycle. lcd_rs/lcd_data show the latched values, lcd_e = 0 (address setup time).
  - E_HIGH: lcd_e = 1 for exactly E_HIGH_CYC cycles, then E_LOW.
  - E_LOW: lcd_e = 0 for exactly E_LOW_CYC cycles, then WAIT.
  - WAIT: lcd_e = 0 for W cycles, then IDLE.
    - W = LONG_WAIT_CYC if rs = 0 and data is 8'h01, 8'h02 or 8'h03.
    - W = CMD_WAIT_CYC otherwise.
- lcd_rs and lcd_data stay constant from SETUP through the end of WAIT. They keep their last values in IDLE.
- Latency: if the transfer happens at cycle T, then lcd_e rises at T+2.
- busy timing: busy is high from T+1 for 1 + E_HIGH_CYC + E_LOW_CYC + W cycles. The next acceptance is possible in the first IDLE cycle after that.
- Back-to-back requests: no idle bubble is added beyond the single IDLE cycle.
- A requester holding valid continuously while the other is also valid gets alternate slots.

Test Plan (sim params E_HIGH_CYC = 4, E_LOW_CYC = 4, CMD_WAIT_CYC = 10, LONG_WAIT_CYC = 50):
- Reset behaviour: after release, req0 sends rs = 0, data 8'h38.
  - Expect req0_ready high in the same cycle, and lcd_e high for exactly 4 cycles starting 2 cycles later with lcd_data = 8'h38, lcd_rs = 0.
  - Expect busy high for 19 cycles.
- Long wait: req1 sends rs = 0, 8'h01, then 8'h06.
  - After 8'h01, busy is high for 59 cycles before 8'h06 is accepted.
  - After 8'h06, busy is high for 19 cycles.
- Contention: req0 and req1 held valid continuously with 8'h41 and 8'h42 (rs = 1).
  - lcd_data sequence is 41, 42, 41, 42.
  - last_grant toggles each transaction.
  - The two ready signals are never high together.
- Busy rejection: req1 asserts valid at cycle 3 of req0's E_HIGH.
  - req1_ready stays 0 until IDLE; req1's byte is written next with unchanged rs/data.
- Reset mid-pulse: assert reset_btn = 0 during E_HIGH.
  - lcd_e, busy and lcd_data go to 0/0/00 immediately.
  - After release, a new req0 write completes normally.
- Idle stability: no valid for 100 cycles.
  - lcd_e stays 0, busy stays 0, lcd_data holds the last written byte, lcd_rw = 0 throughout.
